frame_denorm: RTL
=================

Name: frame_denorm

Overview:
- Inverse of the output rounding stage: expands narrow W_IN-bit signed samples back to W_OUT-bit working width.
- Per-frame block-floating-point denormalisation: each sample is placed in the output MSBs, then arithmetic-right-shifted by a frame exponent latched at start of frame.
- Sits at the input of the FFT/DSP chain, feeding wide samples from narrow transport.
- Tracks frame length; flags framing errors.

Parameters:
- W_IN, 16, input sample width (signed).
- W_OUT, 32, output sample width (signed); must be greater than W_IN.
- FRAME_LEN, 256, samples per frame; must be at least 2.
- SH_W, 6, width of exponent field.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- i_data  input  W_IN  signed input sample.
- i_vld  input  1  input sample valid.
- i_sop  input  1  start of frame; qualified by i_vld.
- i_shift  input  SH_W  frame exponent; sampled only on a valid i_sop beat.
- o_data  output  W_OUT  denormalised sample.
- o_vld  output  1  output valid.
- o_sop  output  1  first sample of frame; qualified by o_vld.
- o_eop  output  1  last (FRAME_LEN-th) sample of frame; qualified by o_vld.
- o_err  output  1  one-cycle framing error pulse.

Behaviour:
- Reset (rst low, async assert): o_data=0, o_vld=0, o_sop=0, o_eop=0, o_err=0, state IDLE, counter 0, latched shift 0.
- Reset release is synchronous to clk.
- No backpressure. Every accepted beat produces its output exactly 2 cycles after the i_vld cycle. Fully pipelined, 1 sample/cycle sustained.
- Pipeline stages:
  - Stage 1 registers the sample, effective shift, flags and error.
  - Stage 2 performs the shift and drives the outputs.
- Arithmetic: o_data = ({i_data, (W_OUT-W_IN) zeros} as signed) >>> sh, sign-filling from the left.
- Shift clamp: sh = min(latched shift, W_OUT-1), giving result 0 or all-ones at the limit.
- o_data holds its last value when o_vld=0.
- States IDLE and FRAME; counter cnt counts 0..FRAME_LEN-1.
- IDLE:
  - Valid beat with i_sop: latch i_shift, emit with o_sop, cnt=1, go to FRAME.
  - Valid beat without i_sop: sample dropped (o_vld stays 0); o_err pulses at that beat's output slot.
- FRAME, valid beat without i_sop:
  - Emit the sample, cnt++.
  - If cnt was FRAME_LEN-1: emit with o_eop, cnt=0, go to IDLE.
- FRAME, valid beat with i_sop (premature restart):
  - Emit with o_sop=1 and o_err=1 in the same cycle.
  - Relatch i_shift, cnt=1, stay in FRAME.
  - The truncated frame gets no o_eop.
- i_sop while i_vld=0: ignored. Gaps (i_vld=0) inside a frame are allowed and do not advance cnt.
- The new exponent applies from the sop beat itself; beats already in the pipeline keep their own exponent, carried per-beat in stage 1.
- o_sop and o_eop are never both high (FRAME_LEN>=2).
- Reset mid-frame: the pipeline flushes with no output. After release the block is in IDLE and needs a new sop.

Decomposition:
- Shared package dsp_pkg holds:
  - state enum (IDLE, FRAME).
  - function clamp_shift(shift, limit).
- One sub-module, frame_denorm_shift: registered arithmetic barrel shifter (W_OUT data in, shift in, valid/flags passthrough), forming stage 2.
- Framing FSM and counter stay in the top.

Test Plan:
All scenarios use W_IN=16, W_OUT=32, SH_W=6, FRAME_LEN=4.
- Basic expansion: sop beat with i_data=0x1234, i_shift=0 -> two cycles later o_vld=1, o_sop=1, o_data=0x12340000.
- Sign extension: sop, i_shift=4, data 0x8000, then 0x7FFF -> 0xF8000000 then 0x07FFF000.
- Clamp: sop, i_shift=40, then data 0x7FFF and 0x8000 -> 0x00000000 and 0xFFFFFFFF.
- Frame length and gaps:
  - 4 beats with i_vld gaps -> o_eop only on the 4th output.
  - Following beat without sop -> no o_vld, o_err pulse 2 cycles later.
- Premature restart: sop, 1 beat, then sop with i_shift=8 -> third output has o_sop=1, o_err=1, shift 8; o_eop on the 4th beat of the new frame.
- Async reset: assert rst low mid-frame between edges -> outputs 0 immediately. After release, data without sop is dropped with o_err; the next sop is processed normally.

Source files
------------

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared types and helpers for the input-side DSP blocks.
//   frame_state_t  - framing FSM states
//   beat_flags_t   - per-beat framing flags carried down the pipeline
//   clamp_shift()  - saturate a shift amount to a limit
package dsp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } frame_state_t;

  typedef struct packed {
    logic sop;
    logic eop;
    logic err;
  } beat_flags_t;

  // Shifts beyond the data width add nothing but sign bits, so they are
  // saturated to the largest meaningful amount.
  function automatic int unsigned clamp_shift(input int unsigned shift,
                                              input int unsigned limit);
    return (shift > limit) ? limit : shift;
  endfunction

endpackage

// File: rtl/frame_denorm_shift.sv
// frame_denorm_shift: registered arithmetic barrel shifter (output stage).
//   clk, rst   - clock, async active-low reset
//   d, sh      - left-justified sample and its (already clamped) shift
//   vld, flg   - beat valid and framing flags from the previous stage
//   o_data     - d >>> sh, held when no valid beat arrives
//   o_vld/o_sop/o_eop/o_err - registered qualifiers
module frame_denorm_shift
  import dsp_pkg::*;
#(
  parameter int W_OUT = 32,
  parameter int SH_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_OUT-1:0] d,
  input  logic [SH_W-1:0]  sh,
  input  logic             vld,
  input  beat_flags_t      flg,
  output logic [W_OUT-1:0] o_data,
  output logic             o_vld,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_err
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_data <= '0;
      o_vld  <= 1'b0;
      o_sop  <= 1'b0;
      o_eop  <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      if (vld) o_data <= $signed(d) >>> sh;
      o_vld <= vld;
      o_sop <= vld & flg.sop;
      o_eop <= vld & flg.eop;
      // A dropped beat still reports its error, with no valid.
      o_err <= flg.err;
    end
  end

endmodule

// File: rtl/frame_denorm.sv
// frame_denorm: block-floating-point denormaliser. Places each W_IN-bit
// sample in the MSBs of a W_OUT-bit word and arithmetic-right-shifts it by
// the exponent latched on the frame's sop beat. Two-cycle latency, no stall.
//   clk, rst         - clock, async active-low reset
//   i_data, i_vld    - narrow signed sample and its valid
//   i_sop, i_shift   - start of frame and frame exponent (sop beat only)
//   o_data, o_vld    - wide denormalised sample and its valid
//   o_sop, o_eop     - first / FRAME_LEN-th sample of a frame
//   o_err            - framing error pulse (orphan beat or early restart)
module frame_denorm
  import dsp_pkg::*;
#(
  parameter int W_IN      = 16,
  parameter int W_OUT     = 32,
  parameter int FRAME_LEN = 256,
  parameter int SH_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_IN-1:0]  i_data,
  input  logic             i_vld,
  input  logic             i_sop,
  input  logic [SH_W-1:0]  i_shift,
  output logic [W_OUT-1:0] o_data,
  output logic             o_vld,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_err
);

  localparam int PAD   = W_OUT - W_IN;
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // framing state
  frame_state_t    state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SH_W-1:0]  sh_lat, sh_lat_n;

  // current-beat decisions
  logic            emit;
  beat_flags_t     flg;
  logic [SH_W-1:0] eff_sh;

  // stage 1
  logic             s1_vld;
  beat_flags_t      s1_flg;
  logic [W_OUT-1:0] s1_data;
  logic [SH_W-1:0]  s1_sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sh_lat <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sh_lat <= sh_lat_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sh_lat_n = sh_lat;
    emit     = 1'b0;
    flg      = '0;
    eff_sh   = sh_lat;
    if (i_vld) begin
      if (i_sop) begin
        // The new exponent applies to the sop beat itself; a sop inside a
        // frame truncates it (no eop) and flags the restart.
        sh_lat_n = i_shift;
        eff_sh   = i_shift;
        emit     = 1'b1;
        flg.sop  = 1'b1;
        flg.err  = (state == FRAME);
        cnt_n    = CNT_ONE;
        state_n  = FRAME;
      end else if (state == IDLE) begin
        flg.err = 1'b1;               // orphan beat: dropped
      end else begin
        emit = 1'b1;
        if (cnt == CNT_LAST) begin
          flg.eop = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
    end
  end

  // Each beat carries its own shift so in-flight beats are unaffected by a
  // following sop that relatches the exponent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_flg  <= '0;
      s1_data <= '0;
      s1_sh   <= '0;
    end else begin
      s1_vld  <= emit;
      s1_flg  <= flg;
      s1_data <= {i_data, {PAD{1'b0}}};
      s1_sh   <= SH_W'(clamp_shift(32'(eff_sh), W_OUT - 1));
    end
  end

  frame_denorm_shift #(
    .W_OUT (W_OUT),
    .SH_W  (SH_W)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .d      (s1_data),
    .sh     (s1_sh),
    .vld    (s1_vld),
    .flg    (s1_flg),
    .o_data (o_data),
    .o_vld  (o_vld),
    .o_sop  (o_sop),
    .o_eop  (o_eop),
    .o_err  (o_err)
  );

endmodule
